// File: rtl/mlp_result_drain_pkg.sv
// Shared types for the MLP result drain: the signed result word and the
// FIFO entry that tags each word with its end-of-frame marker.
package mlp_result_drain_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] result_t;

    typedef struct packed {
        logic    last;
        result_t data;
    } drain_entry_t;

    localparam int ENTRY_W = $bits(drain_entry_t);

endpackage

// File: rtl/mlp_result_drain_if.sv
// Valid/ready result stream leaving the drain; master drives the word,
// slave (the classification consumer) drives ready.
interface mlp_result_drain_if;
    import mlp_result_drain_pkg::*;

    logic    valid;
    logic    ready;
    result_t payload;
    logic    last;

    modport master (output valid, output payload, output last, input ready);
    modport slave  (input valid, input payload, input last, output ready);

endinterface

// File: rtl/mlp_result_drain_fifo.sv
// Synchronous FIFO with the head entry read straight out of the storage flops,
// so a word written at one edge is visible only after that edge.
module mlp_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr];

    // Caller guarantees push only when not full (or popping) and pop only when not empty.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mlp_result_drain.sv
// Captures the MLP core's unthrottled result beats, re-issues them on a
// valid/ready stream with frame-end tags, and reports per-frame signed argmax.
module mlp_result_drain
    import mlp_result_drain_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 10,
    parameter int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1,
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    input  result_t            in_payload_i,
    mlp_result_drain_if.master out_if,
    output logic               argmax_valid_o,
    output logic [IDX_W-1:0]   argmax_idx_o,
    output result_t            argmax_val_o,
    output logic               overflow_o,
    output logic [LVL_W-1:0]   level_o
);

    drain_entry_t     wr_entry;
    drain_entry_t     head_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic             do_push;
    logic             do_pop;
    logic             last_beat;
    logic             beat_wins;
    logic [IDX_W-1:0] frame_cnt;
    logic [IDX_W-1:0] run_idx;
    logic [IDX_W-1:0] next_idx;
    result_t          run_max;
    result_t          next_max;

    assign out_if.valid   = !fifo_empty;
    assign out_if.payload = head_entry.data;
    assign out_if.last    = head_entry.last;

    // A full FIFO still accepts a word when the consumer frees a slot in the same cycle.
    assign do_pop    = !fifo_empty && out_if.ready;
    assign do_push   = in_valid_i && (!fifo_full || do_pop);
    assign last_beat = (frame_cnt == IDX_W'(FRAME_LEN - 1));
    assign wr_entry  = '{last: last_beat, data: in_payload_i};

    // Beat 0 always seeds the running max; later beats need a strictly larger value.
    assign beat_wins = (frame_cnt == '0) || (in_payload_i > run_max);
    assign next_max  = beat_wins ? in_payload_i : run_max;
    assign next_idx  = beat_wins ? frame_cnt : run_idx;

    mlp_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (do_push),
        .wdata  (wr_entry),
        .pop    (do_pop),
        .rdata  (head_entry),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level_o)
    );

    // Frame tracking advances on every beat, dropped or not, to keep alignment.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            frame_cnt      <= '0;
            run_max        <= '0;
            run_idx        <= '0;
            argmax_valid_o <= 1'b0;
            argmax_idx_o   <= '0;
            argmax_val_o   <= '0;
            overflow_o     <= 1'b0;
        end else begin
            argmax_valid_o <= 1'b0;
            if (in_valid_i) begin
                frame_cnt <= last_beat ? '0 : frame_cnt + 1'b1;
                run_max   <= next_max;
                run_idx   <= next_idx;
                if (last_beat) begin
                    argmax_valid_o <= 1'b1;
                    argmax_idx_o   <= next_idx;
                    argmax_val_o   <= next_max;
                end
                if (!do_push) overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mlp_result_drain.md
Name: mlp_result_drain

Overview:
Downstream of the MLP core. Captures the core's result stream, which has no backpressure: a 16-bit Q-format word is valid for exactly one cycle per beat.
- Buffers the words in a FIFO and re-issues them on a valid/ready stream, tagging the last word of each inference frame.
- Tracks the signed argmax across each frame for the classification consumer.
- Records lost words with a sticky overflow flag.

Parameters:
DATA_W, 16, result word width (signed two's complement)
DEPTH, 16, FIFO entries; power of two, >= 2
FRAME_LEN, 10, result words per inference; >= 1
IDX_W, $clog2(FRAME_LEN) (minimum 1), index width, derived

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, synchronous, active-high (1 = reset)
in_valid_i  in  1  result beat from MLP core, single-cycle pulse
in_payload_i  in  DATA_W  result word
out_valid_o  out  1  FIFO head valid
out_ready_i  in  1  consumer ready
out_payload_o  out  DATA_W  FIFO head word
out_last_o  out  1  head is last word of its frame
argmax_valid_o  out  1  one-cycle pulse: argmax of completed frame
argmax_idx_o  out  IDX_W  index of frame maximum
argmax_val_o  out  DATA_W  value of frame maximum
overflow_o  out  1  sticky: at least one word dropped
level_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_ni=1 at posedge): applies the same cycle it is sampled and overrides all other events in that cycle.
  - Cleared: FIFO (level_o=0, out_valid_o=0), frame counter, running max, argmax outputs (all 0), overflow_o.
  - Reset mid-frame discards the partial frame.
  - out_payload_o/out_last_o are don't-care while out_valid_o=0.
- Push:
  - Occurs when in_valid_i=1 and (level<DEPTH, or a pop occurs the same cycle).
  - Stores entry {last, data}, where last = (frame_cnt==FRAME_LEN-1).
- Pop: out_valid_o && out_ready_i.
- Latency: a word pushed into an empty FIFO at edge t appears at out_valid_o in the cycle following edge t (1-cycle latency). No combinational bypass from input to output.
- Full: level==DEPTH, no pop, in_valid_i=1.
  - The word is dropped and overflow_o is set (sticky until reset).
  - The frame counter and argmax still advance on the dropped word, so frame alignment and argmax stay correct.
- Simultaneous push and pop:
  - When full: legal; level is unchanged.
  - When empty: the pop cannot occur (out_valid_o=0), so push only.
- out_valid_o/out_payload_o/out_last_o:
  - Held stable while out_valid_o && !out_ready_i.
  - Payload comes from the registered head entry.
- Frame counter:
  - Increments on every in_valid_i beat.
  - Wraps to 0 after FRAME_LEN-1.
  - When FRAME_LEN=1, every word is last.
- Argmax:
  - Running max is loaded unconditionally on beat 0 of a frame.
  - On later beats it is replaced only when in_payload_i > max (signed, strict). Ties keep the lowest index.
  - On the last beat the final comparison includes that word. At the next edge, argmax_idx_o/argmax_val_o are registered and argmax_valid_o pulses high for one cycle.
  - Outputs are held until the next frame completes.
- Pointers: wrap modulo DEPTH. level_o is exact 0..DEPTH.
- No arithmetic on data other than the signed compare. Widths are unchanged.

Decomposition:
- mlp_pkg:
  - DATA_W
  - typedef logic signed [DATA_W-1:0] result_t
  - typedef struct packed {logic last; result_t data;} drain_entry_t
- Sub-module mlp_sync_fifo:
  - Parameterised by entry type width and DEPTH.
  - push/pop/full/empty/level.
  - Registered head; no overflow logic inside.
- Top holds the frame counter, argmax, overflow and drop decision.

Test Plan:
- Reset, then one frame of 10 words 0x0001..0x000A (ready=1) -> 10 outputs in order, 1 cycle after each input; out_last_o only on 0x000A; argmax pulse idx=9 val=0x000A; overflow_o=0.
- Frame with negatives {0xFFF0, 0x8000, 0xFFFF, ... rest 0x8000} -> argmax idx=2 val=0xFFFF; ties at 0x8000 ignored; with a duplicate maximum, the lower index is reported.
- out_ready_i=0, 20 consecutive beats 0x0100+i with DEPTH=16 -> level_o=16, overflow_o=1 from beat 16; drain yields 0x0100..0x010F. The beat-9 word is tagged last. The next frame's argmax still fires on the 10th beat after frame start.
- Full FIFO with out_ready_i=1 and in_valid_i=1 in the same cycle -> both pop and push occur; level_o stays 16; overflow_o not set.
- Assert rst_ni=1 for one cycle after 5 of 10 frame beats -> all outputs zero. The next 10 beats form a full frame with last on the 10th, and an argmax pulse follows.
- FRAME_LEN=1 build, beats 0x0003, 0x7FFF -> every output has out_last_o=1; two argmax pulses, each idx=0, with val=0x0003 then 0x7FFF.
